// File: rtl/adder_pipe_pkg.sv
// Shared types for the queued adder: opcode and FSM state encodings.
// The request payload {a,b,op} depends on WIDTH, so its packed struct
// is declared inside the parametrised modules that use it.
package adder_pipe_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/adder_pipe_q_req_fifo.sv
// Request FIFO for adder_pipe_q: DEPTH entries of W bits, order preserving.
// Ports:
//   clk, reset     clock, synchronous active-low reset (empties the FIFO)
//   push, wdata    write request; ignored while full
//   pop            remove head; ignored while empty
//   rdata_c        current head entry (combinational read of storage)
//   full, count    registered occupancy flags, valid before the edge
module req_fifo #(
    parameter int unsigned W     = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata_c,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && (count_q != '0);

    // Occupancy update; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wrap_inc(wptr_q);
            if (pop_ok)  rptr_q <= wrap_inc(rptr_q);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Payload storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= wdata;
    end

    assign rdata_c = mem[rptr_q];
    assign full    = full_q;
    assign count   = count_q;

endmodule

// File: rtl/adder_pipe_q.sv
// Queued ADD/SUB/ACC/CLR unit: requests are buffered in a FIFO, executed one
// at a time over LATENCY cycles, and each result is returned with a 1-cycle ack.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   a, b, op     request operands (unsigned) and opcode, captured when en && !full
//   en           request valid, level-sampled every edge
//   full, count  FIFO full flag and occupancy
//   drop         1-cycle pulse: a request arrived while full and was discarded
//   out, ack     last result (held) and its 1-cycle valid pulse
//   overflow     sticky ACC carry-out of OUT_W, cleared by CLR or reset
module adder_pipe_q
    import adder_pipe_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned OUT_W   = 2*WIDTH,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [1:0]                   op,
    input  logic                         en,
    output logic                         full,
    output logic                         drop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [OUT_W-1:0]             out,
    output logic                         ack,
    output logic                         overflow
);

    localparam int unsigned REQ_W = 2*WIDTH + OP_W;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned SUM_W = OUT_W + 1;
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        op_e              op;
    } req_t;

    req_t             wreq;
    req_t             head;
    logic [REQ_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic [OCC_W-1:0] fifo_count;
    logic             pop;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_q, req_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             ack_q, ack_d;
    logic             drop_q;
    logic [SUM_W-1:0] acc_sum;

    assign wreq = '{a: a, b: b, op: op_e'(op)};
    assign head = req_t'(fifo_rdata);

    req_fifo #(
        .W     (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (en),
        .pop     (pop),
        .wdata   (wreq),
        .rdata_c (fifo_rdata),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Next-state and result logic: pop when idle, finish when the counter expires.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        acc_d   = acc_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        ack_d   = 1'b0;
        pop     = 1'b0;
        acc_sum = '0;
        case (state_q)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    req_d   = head;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    ack_d   = 1'b1;
                    state_d = S_IDLE;
                    case (req_q.op)
                        OP_ADD: out_d = OUT_W'(req_q.a) + OUT_W'(req_q.b);
                        OP_SUB: out_d = OUT_W'(req_q.a) - OUT_W'(req_q.b);
                        OP_ACC: begin
                            // One extra bit catches the carry out of OUT_W.
                            acc_sum = SUM_W'(acc_q) + SUM_W'(req_q.a) + SUM_W'(req_q.b);
                            acc_d   = acc_sum[OUT_W-1:0];
                            out_d   = acc_sum[OUT_W-1:0];
                            if (acc_sum[OUT_W]) ovf_d = 1'b1;
                        end
                        OP_CLR: begin
                            acc_d = '0;
                            out_d = '0;
                            ovf_d = 1'b0;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            ack_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            ack_q   <= ack_d;
            drop_q  <= en && fifo_full;
        end
    end

    assign full     = fifo_full;
    assign count    = fifo_count;
    assign drop     = drop_q;
    assign out      = out_q;
    assign ack      = ack_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_pipe_q.sv
// Bench for adder_pipe_q: three instances (default, LATENCY=8, OUT_W=9)
// share operands and reset; each has its own en.
module tb_adder_pipe_q;
    import adder_pipe_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a_r, b_r;
    logic [1:0]  op_r;
    logic        en_v   [3];
    logic        full_v [3];
    logic        drop_v [3];
    logic        ack_v  [3];
    logic        ovf_v  [3];
    logic [2:0]  cnt_v  [3];
    logic [15:0] out0, out1;
    logic [8:0]  out2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adder_pipe_q #(.WIDTH(8), .OUT_W(16), .DEPTH(4), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .a(a_r), .b(b_r), .op(op_r), .en(en_v[0]),
        .full(full_v[0]), .drop(drop_v[0]), .count(cnt_v[0]), .out(out0),
        .ack(ack_v[0]), .overflow(ovf_v[0]));

    adder_pipe_q #(.WIDTH(8), .OUT_W(16), .DEPTH(4), .LATENCY(8)) dut1 (
        .clk(clk), .reset(reset), .a(a_r), .b(b_r), .op(op_r), .en(en_v[1]),
        .full(full_v[1]), .drop(drop_v[1]), .count(cnt_v[1]), .out(out1),
        .ack(ack_v[1]), .overflow(ovf_v[1]));

    adder_pipe_q #(.WIDTH(8), .OUT_W(9), .DEPTH(4), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .a(a_r), .b(b_r), .op(op_r), .en(en_v[2]),
        .full(full_v[2]), .drop(drop_v[2]), .count(cnt_v[2]), .out(out2),
        .ack(ack_v[2]), .overflow(ovf_v[2]));

    function automatic logic [15:0] get_out(input int idx);
        if (idx == 0) return out0;
        if (idx == 1) return out1;
        return {7'd0, out2};
    endfunction

    function automatic int lat_of(input int idx);
        return (idx == 1) ? 8 : 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One request, then wait (bounded) for its ack and check result and latency.
    task automatic req_wait(input int idx, input op_e o, input logic [7:0] av,
                            input logic [7:0] bv, input logic [15:0] exp_out,
                            input logic exp_ovf, input string name);
        int n;
        op_r = o; a_r = av; b_r = bv;
        en_v[idx] = 1'b1;
        tick();
        en_v[idx] = 1'b0;
        n = 0;
        while (ack_v[idx] !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, lat_of(idx) + 1);
        check({name, " out"}, get_out(idx), exp_out);
        check({name, " overflow"}, ovf_v[idx], exp_ovf);
        check({name, " count"}, cnt_v[idx], 0);
        tick();
        check({name, " ack pulse"}, ack_v[idx], 1'b0);
    endtask

    typedef struct {
        int         idx;
        op_e        op;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] exp_out;
        logic       exp_ovf;
        string      name;
    } vec_t;

    typedef struct {
        op_e        op;
        logic [7:0] a;
        logic [7:0] b;
    } mreq_t;

    // Reference model state for the randomized phase.
    mreq_t       mq[$];
    mreq_t       cur;
    logic [15:0] m_acc, m_out;
    logic        m_ovf;

    task automatic model_exec(input mreq_t r);
        int s;
        case (r.op)
            OP_ADD: m_out = 16'(r.a) + 16'(r.b);
            OP_SUB: m_out = 16'(r.a) - 16'(r.b);
            OP_ACC: begin
                s = int'(m_acc) + int'(r.a) + int'(r.b);
                if (s > 65535) m_ovf = 1'b1;
                m_acc = 16'(s);
                m_out = m_acc;
            end
            default: begin
                m_acc = 16'd0;
                m_out = 16'd0;
                m_ovf = 1'b0;
            end
        endcase
    endtask

    initial begin
        vec_t  vecs[$];
        int    exp_cnt[6];
        logic [15:0] got[8];
        int    nacks;
        logic  busy, full_pre, exp_ack, en_b;
        int    done_t;

        reset = 1'b0;
        a_r = '0; b_r = '0; op_r = '0;
        for (int i = 0; i < 3; i++) en_v[i] = 1'b0;
        tick();
        tick();

        // Reset state on every instance.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset full%0d", i), full_v[i], 0);
            check($sformatf("reset drop%0d", i), drop_v[i], 0);
            check($sformatf("reset count%0d", i), cnt_v[i], 0);
            check($sformatf("reset ack%0d", i), ack_v[i], 0);
            check($sformatf("reset ovf%0d", i), ovf_v[i], 0);
            check($sformatf("reset out%0d", i), get_out(i), 0);
        end
        reset = 1'b1;
        tick();

        // Directed vectors: default arithmetic, accumulator, long latency, 9-bit overflow.
        vecs.push_back('{0, OP_ADD, 8'd7,   8'd1,   16'd8,     1'b0, "add7+1"});
        vecs.push_back('{0, OP_SUB, 8'd6,   8'd8,   16'hFFFE,  1'b0, "sub6-8"});
        vecs.push_back('{0, OP_ADD, 8'd14,  8'd11,  16'd25,    1'b0, "add14+11"});
        vecs.push_back('{0, OP_ACC, 8'd5,   8'd6,   16'd11,    1'b0, "acc5+6"});
        vecs.push_back('{0, OP_ACC, 8'd71,  8'd23,  16'd105,   1'b0, "acc71+23"});
        vecs.push_back('{0, OP_CLR, 8'd9,   8'd9,   16'd0,     1'b0, "clr"});
        vecs.push_back('{0, OP_ACC, 8'd24,  8'd45,  16'd69,    1'b0, "acc24+45"});
        vecs.push_back('{1, OP_ADD, 8'd200, 8'd100, 16'd300,   1'b0, "lat8 add"});
        vecs.push_back('{2, OP_ACC, 8'd255, 8'd255, 16'd510,   1'b0, "w9 acc255"});
        vecs.push_back('{2, OP_ACC, 8'd1,   8'd1,   16'd0,     1'b1, "w9 acc wrap"});
        vecs.push_back('{2, OP_ADD, 8'd1,   8'd1,   16'd2,     1'b1, "w9 add sticky"});
        vecs.push_back('{2, OP_CLR, 8'd0,   8'd0,   16'd0,     1'b0, "w9 clr"});
        foreach (vecs[i])
            req_wait(vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].exp_out, vecs[i].exp_ovf, vecs[i].name);

        // Back-to-back burst into LATENCY=8: fifth push fills, sixth drops.
        exp_cnt = '{1, 1, 2, 3, 4, 4};
        for (int k = 0; k < 6; k++) begin
            op_r = OP_ADD;
            a_r  = 8'(10 * (k + 1));
            b_r  = 8'(k);
            en_v[1] = 1'b1;
            tick();
            check($sformatf("burst count%0d", k), cnt_v[1], exp_cnt[k]);
            check($sformatf("burst full%0d", k), full_v[1], (k >= 4) ? 1 : 0);
            check($sformatf("burst drop%0d", k), drop_v[1], (k == 5) ? 1 : 0);
        end
        en_v[1] = 1'b0;
        tick();
        check("burst drop end", drop_v[1], 0);
        nacks = 0;
        for (int c = 0; c < 80; c++) begin
            if (ack_v[1] === 1'b1) begin
                if (nacks < 8) got[nacks] = out1;
                nacks++;
            end
            tick();
        end
        check("burst ack count", nacks, 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("burst order%0d", k), got[k], 16'(10 * (k + 1) + k));
        check("burst drained", cnt_v[1], 0);
        check("burst full clear", full_v[1], 0);

        // Reset during EXEC with two queued: nothing may complete afterwards.
        for (int k = 0; k < 3; k++) begin
            op_r = OP_ADD; a_r = 8'(k + 1); b_r = 8'd1;
            en_v[0] = 1'b1;
            tick();
        end
        en_v[0] = 1'b0;
        check("midrst queued", cnt_v[0], 2);
        check("midrst no early ack", ack_v[0], 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst out", out0, 0);
        check("midrst count", cnt_v[0], 0);
        check("midrst full", full_v[0], 0);
        nacks = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ack_v[0] === 1'b1) nacks++;
        end
        check("midrst no ack", nacks, 0);
        req_wait(0, OP_ADD, 8'd3, 8'd4, 16'd7, 1'b0, "post-reset add");

        // Randomized traffic on dut0 against a queue-based timing model.
        m_acc = 16'd0; m_ovf = 1'b0; m_out = 16'd7;
        busy = 1'b0; done_t = 0;
        for (int t = 0; t < 400; t++) begin
            en_b = (t < 360) && ($urandom_range(0, 3) != 0);
            op_r = 2'($urandom_range(0, 3));
            a_r  = 8'($urandom);
            b_r  = 8'($urandom);
            en_v[0] = en_b;
            full_pre = (mq.size() == DEPTH);
            exp_ack  = 1'b0;
            if (busy && t == done_t) begin
                model_exec(cur);
                exp_ack = 1'b1;
                busy = 1'b0;
            end else if (!busy && mq.size() != 0) begin
                cur = mq.pop_front();
                busy = 1'b1;
                done_t = t + 2;
            end
            if (en_b && !full_pre) mq.push_back('{op_e'(op_r), a_r, b_r});
            tick();
            check($sformatf("rand ack t%0d", t), ack_v[0], exp_ack);
            check($sformatf("rand drop t%0d", t), drop_v[0], en_b && full_pre);
            check($sformatf("rand count t%0d", t), cnt_v[0], mq.size());
            check($sformatf("rand full t%0d", t), full_v[0], mq.size() == DEPTH);
            check($sformatf("rand out t%0d", t), out0, m_out);
            check($sformatf("rand ovf t%0d", t), ovf_v[0], m_ovf);
        end
        en_v[0] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
